plus_asic_video_irq: RTL and testbench

Second-generation CPC Plus ASIC video/interrupt block, a parametrised successor to the Plus palette/INT glue. It provides:
- a memory-mapped colour RAM covering pens, border and sprite inks;
- a programmable raster interrupt (PRI) alongside the 52 µs frame interrupt, with priority and a Z80 IM2 vector;
- a configurable-latency pixel lookup pipeline.
It sits between the Gate-Array pen output, the MMU-gated ASIC window (0x4000–0x7FFF) and the Z80 INT line.

---
 rtl/plus_asic_video_irq.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_plus_asic_video_irq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plus_asic_video_irq.sv
// ---------------------------------------------------------------------------
// plus_asic_video_irq
//
// CPC Plus ASIC video/interrupt block. It holds the memory-mapped colour RAM
// (pens, border, sprite inks), the programmable raster interrupt (PRI) and
// the delayed frame interrupt, with an IM2 vector and an interrupt FSM. It
// also turns the Gate-Array ink index into RGB through a pixel lookup
// pipeline with configurable latency.
//
// Optional feature macro: PLUS_LINE_READBACK_EN
//   defined   : 0x6806 reads the live line counter and 0x6807 reads
//               {6'b0, frame_pend, raster_pend}
//   undefined : both addresses read 0xFF
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cen_16                pixel clock enable
//   MEM_WR, MEM_RD        CPU write/read strobes (levels, edge-detected here)
//   MEM_A, MEM_D          CPU address and write data
//   rd_data               register read data, valid the cycle after MEM_RD rises
//   rmr2_active           ASIC register window enabled
//   hsync_i, vsync_i      Gate-Array syncs
//   blank_i, ink_i        blanking and ink index for the pixel path
//   cpu_ack               Z80 interrupt-acknowledge cycle
//   int_enable            interrupt enable
//   int_vector, int_n     IM2 vector and active-low INT
//   rgb_r, rgb_g, rgb_b   pixel colour, OUT_BITS per channel
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module plus_asic_video_irq #(
  parameter int CLK_FREQ_HZ  = 32_000_000,
  parameter int NUM_INKS     = 32,
  parameter int PIX_LATENCY  = 2,
  parameter int INT_DELAY_US = 52,
  parameter int OUT_BITS     = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cen_16,
  input  logic                MEM_WR,
  input  logic                MEM_RD,
  input  logic [15:0]         MEM_A,
  input  logic [7:0]          MEM_D,
  output logic [7:0]          rd_data,
  input  logic                rmr2_active,
  input  logic                hsync_i,
  input  logic                vsync_i,
  input  logic                blank_i,
  input  logic [4:0]          ink_i,
  input  logic                cpu_ack,
  input  logic                int_enable,
  output logic [7:0]          int_vector,
  output logic                int_n,
  output logic [OUT_BITS-1:0] rgb_r,
  output logic [OUT_BITS-1:0] rgb_g,
  output logic [OUT_BITS-1:0] rgb_b
);

  localparam int          FRAME_LOAD = (CLK_FREQ_HZ / 1_000_000) * INT_DELAY_US;
  localparam logic [31:0] FRAME_LOAD_W = 32'(FRAME_LOAD);
  localparam logic [15:0] ADDR_PRI  = 16'h6800;
  localparam logic [15:0] ADDR_IVR  = 16'h6805;
`ifdef PLUS_LINE_READBACK_EN
  localparam logic [15:0] ADDR_LINE = 16'h6806;
  localparam logic [15:0] ADDR_STAT = 16'h6807;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_GAP} irq_state_t;

  // Replicate a nibble MSB-first and keep the top OUT_BITS bits.
  function automatic logic [OUT_BITS-1:0] expand(input logic [3:0] n);
    logic [11:0] rep;
    rep = {n, n, n};
    return rep[11 -: OUT_BITS];
  endfunction

  logic        hsync_q, vsync_q, mem_wr_q, mem_rd_q;
  logic        hsync_rise, vsync_fall, wr_stb, rd_stb;
  logic [3:0]  ram_r [NUM_INKS];
  logic [3:0]  ram_g [NUM_INKS];
  logic [3:0]  ram_b [NUM_INKS];
  logic [7:0]  pri;
  logic [4:0]  ivr_base;
  logic [7:0]  line_cnt;
  logic [31:0] frame_timer;
  logic        raster_pend, frame_pend;
  logic        raster_hit, frame_hit;
  logic        any_pend, ack_take, serve_raster, serve_frame;
  logic        in_colour, col_valid;
  logic [4:0]  col_idx;
  logic [7:0]  rd_next;
  logic [5:0]  pix_tap;
  logic        pix_blank;
  logic [4:0]  pix_ink;
  irq_state_t  state;

  // Previous-cycle copies of the level inputs, so each strobe and sync
  // transition is acted on exactly once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      mem_wr_q <= 1'b0;
      mem_rd_q <= 1'b0;
    end else begin
      hsync_q  <= hsync_i;
      vsync_q  <= vsync_i;
      mem_wr_q <= MEM_WR;
      mem_rd_q <= MEM_RD;
    end
  end

  assign hsync_rise = hsync_i & ~hsync_q;
  assign vsync_fall = ~vsync_i & vsync_q;
  assign wr_stb     = MEM_WR & ~mem_wr_q & rmr2_active;
  assign rd_stb     = MEM_RD & ~mem_rd_q;

  // Colour RAM occupies 0x6400..0x643F, two bytes per ink; entries at or
  // beyond NUM_INKS are not decoded.
  assign in_colour = (MEM_A[15:6] == 10'h190);
  assign col_idx   = MEM_A[5:1];
  assign col_valid = in_colour && (int'(col_idx) < NUM_INKS);

  // Colour RAM writes: even byte carries R and B, odd byte carries G.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_INKS; i++) begin
        ram_r[i] <= 4'h0;
        ram_g[i] <= 4'h0;
        ram_b[i] <= 4'h0;
      end
    end else if (wr_stb && col_valid) begin
      if (!MEM_A[0]) begin
        ram_r[col_idx] <= MEM_D[7:4];
        ram_b[col_idx] <= MEM_D[3:0];
      end else begin
        ram_g[col_idx] <= MEM_D[3:0];
      end
    end
  end

  // PRI and IVR registers; the low three IVR bits are supplied by the
  // interrupt source and are never stored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pri      <= 8'h00;
      ivr_base <= 5'h00;
    end else if (wr_stb) begin
      case (MEM_A)
        ADDR_PRI: pri      <= MEM_D;
        ADDR_IVR: ivr_base <= MEM_D[7:3];
        default:  ;
      endcase
    end
  end

  // Read-data selection; anything unmapped, or the closed window, reads 0xFF.
  always_comb begin
    rd_next = 8'hFF;
    if (rmr2_active) begin
      if (col_valid) begin
        rd_next = MEM_A[0] ? {4'h0, ram_g[col_idx]}
                           : {ram_r[col_idx], ram_b[col_idx]};
      end else begin
        case (MEM_A)
          ADDR_PRI:  rd_next = pri;
          ADDR_IVR:  rd_next = {ivr_base, 3'b000};
`ifdef PLUS_LINE_READBACK_EN
          ADDR_LINE: rd_next = line_cnt;
          ADDR_STAT: rd_next = {6'b0, frame_pend, raster_pend};
`endif
          default:   rd_next = 8'hFF;
        endcase
      end
    end
  end

  // Read data is captured once per MEM_RD strobe and then held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= 8'h00;
    end else if (rd_stb) begin
      rd_data <= rd_next;
    end
  end

  // Scanline counter restarts at VSYNC end; the frame timer reloads there
  // and counts down to the frame-interrupt point.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt    <= 8'h00;
      frame_timer <= 32'd0;
    end else begin
      if (vsync_fall) begin
        line_cnt <= 8'h00;
      end else if (hsync_rise) begin
        line_cnt <= line_cnt + 8'd1;
      end
      if (vsync_fall) begin
        frame_timer <= FRAME_LOAD_W;
      end else if (frame_timer != 32'd0) begin
        frame_timer <= frame_timer - 32'd1;
      end
    end
  end

  // Raster compare uses the pre-increment line number; PRI of zero is off.
  assign raster_hit = hsync_rise && (pri != 8'h00) && (line_cnt == pri);
  assign frame_hit  = (frame_timer == 32'd1);

  assign any_pend     = raster_pend | frame_pend;
  assign ack_take     = (state == ST_ASSERT) && cpu_ack && any_pend;
  assign serve_raster = ack_take && raster_pend;
  assign serve_frame  = ack_take && !raster_pend;

  // Interrupt FSM with pending flags. A fresh event in the acknowledge
  // cycle is OR-ed in after the clear so it survives. The GAP state forces
  // one high cycle on int_n between back-to-back interrupts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      int_n       <= 1'b1;
      int_vector  <= 8'h00;
      raster_pend <= 1'b0;
      frame_pend  <= 1'b0;
    end else begin
      raster_pend <= (raster_pend & ~serve_raster) | raster_hit;
      frame_pend  <= vsync_fall ? 1'b0 : ((frame_pend & ~serve_frame) | frame_hit);
      case (state)
        ST_IDLE: begin
          int_n <= 1'b1;
          if (any_pend) begin
            state <= ST_ASSERT;
            int_n <= ~int_enable;
          end
        end
        ST_ASSERT: begin
          if (ack_take) begin
            int_vector <= {ivr_base, (serve_raster ? 2'b00 : 2'b01), 1'b0};
            int_n      <= 1'b1;
            state      <= ST_GAP;
          end else if (!any_pend) begin
            int_n <= 1'b1;
            state <= ST_IDLE;
          end else begin
            int_n <= ~int_enable;
          end
        end
        ST_GAP: begin
          if (any_pend) begin
            state <= ST_ASSERT;
            int_n <= ~int_enable;
          end else begin
            state <= ST_IDLE;
            int_n <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          int_n <= 1'b1;
        end
      endcase
    end
  end

  // Pixel delay line ahead of the lookup; reset fills it with blank.
  generate
    if (PIX_LATENCY == 0) begin : g_nodelay
      assign pix_tap = {blank_i, ink_i};
    end else begin : g_delay
      logic [5:0] pipe [PIX_LATENCY];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PIX_LATENCY; i++) begin
            pipe[i] <= 6'h20;
          end
        end else if (cen_16) begin
          pipe[0] <= {blank_i, ink_i};
          for (int i = 1; i < PIX_LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
          end
        end
      end
      assign pix_tap = pipe[PIX_LATENCY-1];
    end
  endgenerate

  assign pix_blank = pix_tap[5];
  assign pix_ink   = pix_tap[4:0];

  // Registered colour lookup; a same-cycle RAM write is seen one tick later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_r <= '0;
      rgb_g <= '0;
      rgb_b <= '0;
    end else if (cen_16) begin
      if (pix_blank || !(int'(pix_ink) < NUM_INKS)) begin
        rgb_r <= '0;
        rgb_g <= '0;
        rgb_b <= '0;
      end else begin
        rgb_r <= expand(ram_r[pix_ink]);
        rgb_g <= expand(ram_g[pix_ink]);
        rgb_b <= expand(ram_b[pix_ink]);
      end
    end
  end

endmodule

// File: tb/tb_plus_asic_video_irq.sv
// ---------------------------------------------------------------------------
// tb_plus_asic_video_irq
//
// Directed bench for plus_asic_video_irq with default parameters
// (32 MHz, 32 inks, pixel latency 2, 52 us frame delay, 8-bit RGB).
// Inputs change 1 ns after the rising edge and outputs are sampled there.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_plus_asic_video_irq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cen_16 = 1'b1;
  logic        MEM_WR = 1'b0;
  logic        MEM_RD = 1'b0;
  logic [15:0] MEM_A = 16'h0000;
  logic [7:0]  MEM_D = 8'h00;
  logic [7:0]  rd_data;
  logic        rmr2_active = 1'b1;
  logic        hsync_i = 1'b0;
  logic        vsync_i = 1'b0;
  logic        blank_i = 1'b1;
  logic [4:0]  ink_i = 5'd0;
  logic        cpu_ack = 1'b0;
  logic        int_enable = 1'b0;
  logic [7:0]  int_vector;
  logic        int_n;
  logic [7:0]  rgb_r, rgb_g, rgb_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  plus_asic_video_irq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cen_16      (cen_16),
    .MEM_WR      (MEM_WR),
    .MEM_RD      (MEM_RD),
    .MEM_A       (MEM_A),
    .MEM_D       (MEM_D),
    .rd_data     (rd_data),
    .rmr2_active (rmr2_active),
    .hsync_i     (hsync_i),
    .vsync_i     (vsync_i),
    .blank_i     (blank_i),
    .ink_i       (ink_i),
    .cpu_ack     (cpu_ack),
    .int_enable  (int_enable),
    .int_vector  (int_vector),
    .int_n       (int_n),
    .rgb_r       (rgb_r),
    .rgb_g       (rgb_g),
    .rgb_b       (rgb_b)
  );

  // Advance one clock and land just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
    MEM_A  = a;
    MEM_D  = d;
    MEM_WR = 1'b1;
    tick();
    MEM_WR = 1'b0;
    tick();
  endtask

  task automatic mem_read(input logic [15:0] a, output logic [7:0] d);
    MEM_A  = a;
    MEM_RD = 1'b1;
    tick();
    d      = rd_data;
    MEM_RD = 1'b0;
    tick();
  endtask

  task automatic hsync_pulse();
    hsync_i = 1'b1;
    tick();
    hsync_i = 1'b0;
    tick();
  endtask

  task automatic vsync_pulse();
    vsync_i = 1'b1;
    tick();
    vsync_i = 1'b0;
    tick();
  endtask

  task automatic ack_pulse();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #2;
    total++;
    if (int_n !== 1'b1) begin bad++; $display("[TB] FAIL reset_int_n: got %b want 1", int_n); end
    total++;
    if ({rgb_r, rgb_g, rgb_b} !== 24'h000000) begin
      bad++; $display("[TB] FAIL reset_rgb: got %h%h%h want 000000", rgb_r, rgb_g, rgb_b);
    end
    total++;
    if (rd_data !== 8'h00 || int_vector !== 8'h00) begin
      bad++; $display("[TB] FAIL reset_regs: rd_data %h int_vector %h want 00 00", rd_data, int_vector);
    end
    tick();
    tick();
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_colour();
    logic [7:0] d;
    rmr2_active = 1'b1;
    mem_write(16'h6402, 8'hA5);
    mem_write(16'h6403, 8'h0C);
    blank_i = 1'b0;
    ink_i   = 5'd1;
    tick();
    tick();
    total++;
    if (rgb_r !== 8'h00) begin bad++; $display("[TB] FAIL pix_latency_early: got %h want 00", rgb_r); end
    tick();
    total++;
    if (rgb_r !== 8'hAA || rgb_g !== 8'hCC || rgb_b !== 8'h55) begin
      bad++; $display("[TB] FAIL pix_lookup: got %h %h %h want AA CC 55", rgb_r, rgb_g, rgb_b);
    end
    mem_read(16'h6402, d);
    total++;
    if (d !== 8'hA5) begin bad++; $display("[TB] FAIL read_even: got %h want A5", d); end
    mem_read(16'h6403, d);
    total++;
    if (d !== 8'h0C) begin bad++; $display("[TB] FAIL read_odd: got %h want 0C", d); end
    cen_16 = 1'b0;
    ink_i  = 5'd0;
    repeat (4) tick();
    total++;
    if (rgb_r !== 8'hAA) begin bad++; $display("[TB] FAIL cen_hold: got %h want AA", rgb_r); end
    cen_16 = 1'b1;
    repeat (3) tick();
    total++;
    if (rgb_r !== 8'h00) begin bad++; $display("[TB] FAIL ink0_zero: got %h want 00", rgb_r); end
    ink_i   = 5'd1;
    blank_i = 1'b1;
    repeat (3) tick();
    total++;
    if (rgb_g !== 8'h00) begin bad++; $display("[TB] FAIL blank_zero: got %h want 00", rgb_g); end
  endtask

  task automatic test_rmr2_off();
    logic [7:0] d;
    rmr2_active = 1'b0;
    mem_write(16'h6402, 8'h33);
    mem_read(16'h6402, d);
    total++;
    if (d !== 8'hFF) begin bad++; $display("[TB] FAIL closed_read: got %h want FF", d); end
    rmr2_active = 1'b1;
    mem_read(16'h6402, d);
    total++;
    if (d !== 8'hA5) begin bad++; $display("[TB] FAIL closed_write_ignored: got %h want A5", d); end
    mem_write(16'h6440, 8'h77);
    mem_read(16'h6440, d);
    total++;
    if (d !== 8'hFF) begin bad++; $display("[TB] FAIL beyond_inks_read: got %h want FF", d); end
    mem_read(16'h6400, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("[TB] FAIL beyond_inks_alias: got %h want 00", d); end
    mem_write(16'h643F, 8'h5A);
    mem_read(16'h643F, d);
    total++;
    if (d !== 8'h0A) begin bad++; $display("[TB] FAIL last_ink_green: got %h want 0A", d); end
    mem_read(16'h1234, d);
    total++;
    if (d !== 8'hFF) begin bad++; $display("[TB] FAIL unmapped_read: got %h want FF", d); end
  endtask

  task automatic test_raster();
    logic [7:0] d;
    int_enable = 1'b1;
    mem_write(16'h6800, 8'h03);
    mem_write(16'h6805, 8'h47);
    mem_read(16'h6805, d);
    total++;
    if (d !== 8'h40) begin bad++; $display("[TB] FAIL ivr_read: got %h want 40", d); end
    mem_read(16'h6800, d);
    total++;
    if (d !== 8'h03) begin bad++; $display("[TB] FAIL pri_read: got %h want 03", d); end
    vsync_pulse();
    repeat (3) hsync_pulse();
    total++;
    if (int_n !== 1'b1) begin bad++; $display("[TB] FAIL raster_early: got %b want 1", int_n); end
    hsync_pulse();
    total++;
    if (int_n !== 1'b0) begin bad++; $display("[TB] FAIL raster_int: got %b want 0", int_n); end
    ack_pulse();
    total++;
    if (int_vector !== 8'h40 || int_n !== 1'b1) begin
      bad++; $display("[TB] FAIL raster_ack: vector %h int_n %b want 40 1", int_vector, int_n);
    end
    tick();
    total++;
    if (int_n !== 1'b1) begin bad++; $display("[TB] FAIL raster_idle: got %b want 1", int_n); end
  endtask

  task automatic test_frame_timer();
    int n;
    mem_write(16'h6800, 8'h00);
    int_enable = 1'b1;
    vsync_pulse();
    n = 0;
    repeat (4) begin
      hsync_pulse();
      n += 2;
    end
    while (int_n === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    total++;
    if (n < 1655 || n > 1675) begin
      bad++; $display("[TB] FAIL frame_delay: got %0d cycles want 1655..1675", n);
    end
    ack_pulse();
    total++;
    if (int_vector !== 8'h42) begin bad++; $display("[TB] FAIL frame_vector: got %h want 42", int_vector); end
    tick();
    total++;
    if (int_n !== 1'b1) begin bad++; $display("[TB] FAIL frame_idle: got %b want 1", int_n); end
  endtask

  task automatic test_back_to_back();
    int lows;
    mem_write(16'h6800, 8'h03);
    int_enable = 1'b0;
    vsync_pulse();
    repeat (4) hsync_pulse();
    lows = 0;
    repeat (1700) begin
      tick();
      if (int_n !== 1'b1) lows++;
    end
    total++;
    if (lows != 0) begin bad++; $display("[TB] FAIL masked_int: got %0d low cycles want 0", lows); end
    int_enable = 1'b1;
    tick();
    total++;
    if (int_n !== 1'b0) begin bad++; $display("[TB] FAIL enable_int: got %b want 0", int_n); end
    ack_pulse();
    total++;
    if (int_vector !== 8'h40 || int_n !== 1'b1) begin
      bad++; $display("[TB] FAIL first_ack: vector %h int_n %b want 40 1", int_vector, int_n);
    end
    tick();
    total++;
    if (int_n !== 1'b0) begin bad++; $display("[TB] FAIL gap_len: got %b want 0", int_n); end
    ack_pulse();
    total++;
    if (int_vector !== 8'h42 || int_n !== 1'b1) begin
      bad++; $display("[TB] FAIL second_ack: vector %h int_n %b want 42 1", int_vector, int_n);
    end
    tick();
    total++;
    if (int_n !== 1'b1) begin bad++; $display("[TB] FAIL b2b_idle: got %b want 1", int_n); end
  endtask

  task automatic test_reset_mid_assert();
    logic [7:0] d;
    int nonzero;
    blank_i    = 1'b0;
    ink_i      = 5'd1;
    int_enable = 1'b1;
    vsync_pulse();
    repeat (4) hsync_pulse();
    total++;
    if (int_n !== 1'b0 || rgb_r !== 8'hAA) begin
      bad++; $display("[TB] FAIL pre_reset: int_n %b rgb_r %h want 0 AA", int_n, rgb_r);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (int_n !== 1'b1) begin bad++; $display("[TB] FAIL async_int_n: got %b want 1", int_n); end
    total++;
    if ({rgb_r, rgb_g, rgb_b} !== 24'h000000 || int_vector !== 8'h00) begin
      bad++; $display("[TB] FAIL async_clear: rgb %h%h%h vector %h want 000000 00", rgb_r, rgb_g, rgb_b, int_vector);
    end
    #2 reset_n = 1'b1;
    tick();
    nonzero = 0;
    for (int i = 0; i < 64; i++) begin
      mem_read(16'h6400 + 16'(i), d);
      if (d !== 8'h00) nonzero++;
    end
    total++;
    if (nonzero != 0) begin bad++; $display("[TB] FAIL ram_cleared: got %0d nonzero want 0", nonzero); end
    mem_read(16'h6800, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("[TB] FAIL pri_cleared: got %h want 00", d); end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_colour();
    test_rmr2_off();
    test_raster();
    test_frame_timer();
    test_back_to_back();
    test_reset_mid_assert();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
